// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider_pkg
//  Description : Shared types and width helpers for the sequential
//                restoring divider and its one-row step.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Plain-vector copies of the state encoding for the legacy-style FSM.
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    // Dividend width follows from the divisor and quotient widths.
    function automatic int calc_dvd_w(input int div_w, input int q_w);
        return div_w + q_w - 1;
    endfunction

    // Step counter must hold Q_W-1.
    function automatic int calc_cnt_w(input int q_w);
        return (q_w > 1) ? $clog2(q_w) : 1;
    endfunction

    localparam int C_DEF_DIV_W = 3;
    localparam int C_DEF_Q_W   = 4;
    localparam int C_DEF_CNT_W = calc_cnt_w(C_DEF_Q_W);

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider_if
//  Description : Operand and result handshake bundle for the divider.
//                slave = divider side, master = source/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int DIV_W = 3,
    parameter int Q_W   = 4
);
    import seq_restoring_divider_pkg::*;

    localparam int DVD_W = calc_dvd_w(DIV_W, Q_W);

    logic             in_valid;
    logic             in_ready;
    logic [DVD_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [Q_W-1:0]   quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    logic             busy;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
               div_by_zero, overflow, busy
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
               div_by_zero, overflow, busy
    );

endinterface
`default_nettype wire

// File: rtl/restoring_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_div_step
//  Description : One combinational restoring-division row: shift in the next
//                dividend bit, trial-subtract the divisor, keep or restore.
//  Revision    : 1.0 - initial release
// ============================================================================
module restoring_div_step #(
    parameter int DIV_W = 3
) (
    input  logic [DIV_W-1:0] i_partial,
    input  logic             i_dvd_bit,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_q_bit,
    output logic [DIV_W-1:0] o_next_partial
);
    // The shifted value is DIV_W+1 bits wide; its MSB is the partial's MSB.
    // A set MSB means the value already exceeds any DIV_W-bit divisor, and
    // since the true difference is below the divisor, the low DIV_W bits of
    // the wrapped subtraction are exact.
    logic [DIV_W-1:0] w_shifted;
    logic [DIV_W-1:0] w_trial;

    assign w_shifted      = {i_partial[DIV_W-2:0], i_dvd_bit};
    assign w_trial        = w_shifted - i_divisor;
    assign o_q_bit        = i_partial[DIV_W-1] | (w_shifted >= i_divisor);
    assign o_next_partial = o_q_bit ? w_trial : w_shifted;

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                clock MSB first, with valid/ready on both sides and
//                divide-by-zero / quotient-overflow short-cuts.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int DIV_W = 3,
    parameter int Q_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);
    localparam int DVD_W = calc_dvd_w(DIV_W, Q_W);
    localparam int CNT_W = calc_cnt_w(Q_W);
    localparam logic [Q_W-1:0]   C_Q_ONES  = '1;
    localparam logic [CNT_W-1:0] C_CNT_TOP = CNT_W'(Q_W - 1);

    logic [1:0]       r_state;
    logic [Q_W-1:0]   r_dvd_lo;
    logic [DIV_W-1:0] r_divisor;
    logic [DIV_W-1:0] r_partial;
    logic [CNT_W-1:0] r_cnt;
    logic [Q_W-1:0]   r_q_acc;
    logic [Q_W-1:0]   r_quotient;
    logic [DIV_W-1:0] r_remainder;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_is_zero;
    logic             w_is_ovf;
    logic             w_dvd_bit;
    logic             w_last;
    logic             w_q_bit;
    logic [DIV_W-1:0] w_dvd_top;
    logic [DIV_W-1:0] w_next_partial;
    logic [Q_W-1:0]   w_q_bit_vec;

    assign w_accept    = bus.in_valid && (r_state == S_IDLE);
    assign w_dvd_top   = {1'b0, bus.dividend[DVD_W-1:Q_W]};
    assign w_is_zero   = (bus.divisor == '0);
    // Quotient fits in Q_W bits only if the top dividend bits are below the divisor.
    assign w_is_ovf    = (w_dvd_top >= bus.divisor);
    assign w_dvd_bit   = r_dvd_lo[r_cnt];
    assign w_last      = (r_cnt == '0);
    assign w_q_bit_vec = Q_W'(w_q_bit) << r_cnt;

    restoring_div_step #(
        .DIV_W (DIV_W)
    ) u_step (
        .i_partial      (r_partial),
        .i_dvd_bit      (w_dvd_bit),
        .i_divisor      (r_divisor),
        .o_q_bit        (w_q_bit),
        .o_next_partial (w_next_partial)
    );

    // Control FSM plus the reset-cleared result and iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_partial   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_zero) begin
                            r_quotient  <= C_Q_ONES;
                            r_remainder <= bus.dividend[DIV_W-1:0];
                            r_dbz       <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_state     <= S_DONE;
                        end else if (w_is_ovf) begin
                            r_quotient  <= C_Q_ONES;
                            r_remainder <= '0;
                            r_dbz       <= 1'b0;
                            r_ovf       <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_partial   <= w_dvd_top;
                            r_cnt       <= C_CNT_TOP;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_partial <= w_next_partial;
                    if (w_last) begin
                        r_quotient  <= r_q_acc | w_q_bit_vec;
                        r_remainder <= w_next_partial;
                        r_dbz       <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand capture at accept and quotient-bit accumulation during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd_lo  <= '0;
            r_divisor <= '0;
            r_q_acc   <= '0;
        end else if (w_accept) begin
            r_dvd_lo  <= bus.dividend[Q_W-1:0];
            r_divisor <= bus.divisor;
            r_q_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_q_acc   <= r_q_acc | w_q_bit_vec;
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.busy        = (r_state == S_RUN);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative, parametrised restoring divider: one quotient bit per clock, MSB first, using a single subtract-and-restore row instead of Q_W unrolled rows.
- Adds capabilities the unrolled combinational array lacks:
  - valid/ready handshake on both sides;
  - divide-by-zero and quotient-overflow detection;
  - registered, stable outputs under backpressure.
- Sits between the operand source and the result consumer in the divider datapath.
- Unsigned operands only.

Parameters:
- DIV_W, 3, divisor width in bits (>= 2).
- Q_W, 4, quotient width in bits (>= 2).
- DVD_W, DIV_W+Q_W-1, dividend width. Derived; must not be overridden.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Operands valid.
- in_ready  out  1  Block can accept operands.
- dividend  in  DVD_W  Unsigned dividend.
- divisor  in  DIV_W  Unsigned divisor.
- out_valid  out  1  Result valid.
- out_ready  in  1  Consumer accepts result.
- quotient  out  Q_W  Unsigned quotient.
- remainder  out  DIV_W  Unsigned remainder, < divisor on normal completion.
- div_by_zero  out  1  Result flag: divisor was 0.
- overflow  out  1  Result flag: true quotient does not fit in Q_W bits.
- busy  out  1  High in RUN.

Behaviour:
- Reset:
  - rst sampled high forces state IDLE.
  - Clears quotient, remainder, both flags, the internal partial-remainder register and the step counter.
  - After reset: in_ready=1, out_valid=0, busy=0.
  - rst has priority over every other event, including mid-RUN and in DONE; any in-flight transaction is discarded with no output.
- States:
  - IDLE: in_ready=1.
  - RUN: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: the transaction is accepted at the edge where in_valid && in_ready. Operands are registered at that edge. The registered operands are never re-sampled afterwards.
- Classification at accept, in priority order:
  - divisor==0 → DONE. quotient=all-ones, remainder=dividend[DIV_W-1:0], div_by_zero=1, overflow=0.
  - dividend[DVD_W-1:Q_W] >= divisor → DONE. quotient=all-ones, remainder=0, overflow=1, div_by_zero=0.
  - Otherwise → RUN. Partial remainder = {1'b0, dividend[DVD_W-1:Q_W]} (DIV_W bits). Step counter = Q_W-1.
- RUN, once per cycle, with k = counter value:
  - trial = {partial, dividend_bit[k]} - {1'b0, divisor}, computed at DIV_W+1 bits.
  - If trial has no borrow: q[k]=1 and partial = trial[DIV_W-1:0].
  - Otherwise: q[k]=0 and partial = {partial, bit}[DIV_W-1:0] (restore).
  - At k==0: load quotient/remainder, clear flags, go to DONE.
  - Otherwise decrement the counter.
- Latency, counting the accept cycle as cycle 0:
  - Normal: out_valid first high in cycle Q_W+1.
  - Exceptions: out_valid first high in cycle 1.
- DONE:
  - out_valid, quotient, remainder and flags are held stable while out_ready=0.
  - out_valid && out_ready → IDLE on the next edge; out_valid drops and in_ready rises in the same cycle.
  - No acceptance in DONE. Minimum spacing between accepts is Q_W+2 cycles.
- Outputs retain their last value in IDLE/RUN but are qualified only by out_valid.
- Input changes during RUN/DONE have no effect.

Decomposition:
- divider_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - a function computing DVD_W from DIV_W, Q_W;
  - a localparam for the counter width, clog2(Q_W).
- One sub-module: restoring_div_step. Purely combinational, parametrised by DIV_W.
  - Inputs: partial, next dividend bit, divisor.
  - Outputs: q_bit and next partial.
  - Reused by a future unrolled/pipelined variant.

Test Plan (DIV_W=3, Q_W=4, DVD_W=6):
- dividend=45, divisor=5, out_ready=1 → out_valid in cycle 5 with quotient=9, remainder=0, flags 0; in_ready=1 in cycle 6.
- dividend=59, divisor=7 → quotient=8, remainder=3. Then dividend=46, divisor=7 back-to-back at first in_ready → quotient=6, remainder=4.
- dividend=13, divisor=0 → out_valid in cycle 1, div_by_zero=1, quotient=15, remainder=5, overflow=0.
- dividend=63, divisor=3 → out_valid in cycle 1, overflow=1, quotient=15, remainder=0. Boundary case dividend=47, divisor=3 (top bits 2<3) → quotient=15, remainder=2, overflow=0.
- Backpressure: result of 45/5 held with out_ready=0 for 6 cycles → outputs constant, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 → single handshake, IDLE next cycle.
- Reset mid-RUN: accept 45/5, assert rst in cycle 2 → cycle 3: in_ready=1, out_valid=0, busy=0. A new 20/3 → quotient=6, remainder=2. No stale result is ever emitted.
